mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port system RAM between the instruction-fetch path (PC side) and the data path (LDUR/STUR from the D-format control word) in the multi-cycle LEGv8 core.
- Arbitrates, sequences one RAM access at a time with a fixed read latency, and returns one-cycle acks.
- Drives a stall to the control-unit state register so the datapath holds while an access is outstanding.

Parameters:
- ADDR_W, 64, width of all address buses.
- DATA_W, 64, data-port and RAM data width.
- WAIT_STATES, 1, cycles from mem_en to valid mem_rdata (0 = combinational RAM); legal range 0..15.
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch waits; legal range 1..15.

Ports:
- clock, input, 1, rising-edge clock for all state.
- reset, input, 1, asynchronous, active-low; 0 resets the block.
- if_req, input, 1, fetch request (level).
- if_addr, input, ADDR_W, fetch byte address.
- if_rdata, output, 32, fetched instruction.
- if_ack, output, 1, one-cycle fetch completion.
- d_req, input, 1, data request (level).
- d_we, input, 1, 1 = store, 0 = load.
- d_addr, input, ADDR_W, data byte address.
- d_wdata, input, DATA_W, store data.
- d_rdata, output, DATA_W, load data.
- d_ack, output, 1, one-cycle data completion.
- mem_en, output, 1, RAM access strobe.
- mem_we, output, 1, RAM write strobe.
- mem_addr, output, ADDR_W, RAM address.
- mem_wdata, output, DATA_W, RAM write data.
- mem_rdata, input, DATA_W, RAM read data.
- stall, output, 1, hold request to the control unit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; data_streak=0; wait counter=0; mask flags cleared.
  - Any in-flight access is aborted immediately, with mem_en dropping in the same cycle; no ack is ever issued for it.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE arbitration (the port acked in the previous cycle is masked for this one cycle):
  - d_req && (!if_req || data_streak < MAX_DATA_BURST) -> grant data; data_streak+1 (saturating).
  - Else if_req -> grant fetch; data_streak=0.
  - On grant: latch address, d_we, d_wdata and the granted port; go to ACCESS.
  - No unmasked request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_addr = latched address; mem_we = latched d_we on a data grant, else 0; mem_wdata = latched data.
  - If WAIT_STATES=0, sample mem_rdata this cycle and go to RESP; else load the counter with WAIT_STATES and go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0; counter decrements each cycle.
  - On the cycle the counter reaches 0, sample mem_rdata and go to RESP.
- RESP (1 cycle):
  - Pulse the granted port's ack.
  - Fetch: if_rdata <= mem_rdata[31:0].
  - Load: d_rdata <= mem_rdata.
  - Store: d_rdata unchanged.
  - Next state IDLE, with the acked port masked for that IDLE cycle.
- Latency: request first seen in IDLE at cycle N -> ack high at cycle N+2+WAIT_STATES.
- rdata outputs hold their value until the next completion of the same port.
- Request inputs are sampled only in IDLE; later changes to addr/data/we are ignored.
- A request dropped after grant still completes and still acks.
- stall=1 in ACCESS and WAIT, and in IDLE when any unmasked request is present; stall=0 in RESP and in an idle IDLE.
- Simultaneous if_req and d_req: data wins unless data_streak == MAX_DATA_BURST.
- Address low bits are passed through unchanged; no alignment checking.

Test Plan:
- Reset released, single fetch: if_addr=0x40, WAIT_STATES=1, RAM[0x40]=0x8B020020 -> mem_en high 1 cycle after request, if_ack at cycle N+3, if_rdata=0x8B020020, stall low in the ack cycle.
- Load vs. store:
  - d_we=0, d_addr=0x100, RAM=0x1234 -> d_ack, d_rdata=0x1234.
  - Then d_we=1, d_wdata=0xDEAD -> mem_we=1 only in the ACCESS cycle, d_rdata stays 0x1234, RAM[0x100]=0xDEAD.
- Fairness: if_req and d_req held high continuously with MAX_DATA_BURST=4 -> grant order D,D,D,D,F,D,D,D,D,F; no port acked in consecutive IDLE-sampled grants.
- Masking: d_req held high through the d_ack cycle, if_req low -> exactly one idle cycle with no mem_en, then a second data access starts.
- Mid-access reset: assert reset=0 during WAIT -> mem_en, stall and acks go to 0 immediately; after release, no ack is generated for the aborted access.
- WAIT_STATES=0 build: fetch issued in IDLE at cycle N -> if_ack at cycle N+2, data equals the value mem_rdata had in the ACCESS cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and RAM port shared by the LEGv8 memory arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    // Core + RAM view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and LDUR/STUR data path.
// One access at a time: IDLE -> ACCESS -> WAIT (WAIT_STATES cycles) -> RESP.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STREAK_W = 4;
    localparam logic [CNT_W-1:0]    WAIT_LD    = CNT_W'(WAIT_STATES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                data_q, data_d;        // 1 = data port granted
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mask_if_q, mask_d_q;
    logic                mem_en_q, mem_we_q;
    logic                if_ack_q, d_ack_q;
    logic [31:0]         if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic sample_c;
    logic stall_c;
    logic pick_data_c;
    logic pick_fetch_c;

    // Raw winner by burst rule; a masked winner simply waits one IDLE cycle.
    assign pick_data_c  = bus.d_req && (!bus.if_req || (streak_q < STREAK_MAX));
    assign pick_fetch_c = bus.if_req && !pick_data_c;

    // Next-state, grant latching and read-data sample strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        data_d   = data_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sample_c = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = (bus.if_req && !mask_if_q) || (bus.d_req && !mask_d_q);
                if (pick_data_c && !mask_d_q) begin
                    state_d  = ST_ACCESS;
                    data_d   = 1'b1;
                    we_d     = bus.d_we;
                    addr_d   = bus.d_addr;
                    wdata_d  = bus.d_wdata;
                    streak_d = (streak_q == STREAK_MAX) ? streak_q
                                                        : streak_q + STREAK_W'(1);
                end else if (pick_fetch_c && !mask_if_q) begin
                    state_d  = ST_ACCESS;
                    data_d   = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = bus.if_addr;
                    streak_d = '0;
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (WAIT_STATES == 0) begin
                    sample_c = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d   = WAIT_LD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    sample_c = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset aborts any access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            data_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_if_q  <= 1'b0;
            mask_d_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            data_q    <= data_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_if_q <= (state_q == ST_RESP) && !data_q;
            mask_d_q  <= (state_q == ST_RESP) && data_q;
            mem_en_q  <= (state_d == ST_ACCESS);
            mem_we_q  <= (state_d == ST_ACCESS) && data_d && we_d;
            if_ack_q  <= sample_c && !data_q;
            d_ack_q   <= sample_c && data_q;
            if (sample_c && !data_q) begin
                if_rdata_q <= bus.mem_rdata[31:0];
            end
            if (sample_c && data_q && !we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Stall is combinational in IDLE so the core holds in the request cycle.
    assign bus.stall     = stall_c && reset;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one-wait-state and zero-wait-state builds.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus0 ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_STATES(1), .MAX_DATA_BURST(4))
        dut1 (.clock(clk), .reset(rst_n), .bus(bus1));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_STATES(0), .MAX_DATA_BURST(4))
        dut0 (.clock(clk), .reset(rst_n), .bus(bus0));

    // RAM models; preload port used only while the DUTs are in reset.
    logic        pre_we;
    logic [8:0]  pre_idx;
    logic [63:0] pre_data;
    logic [63:0] ram1 [0:511];
    logic [63:0] ram0 [0:511];
    logic [63:0] rd_pipe1;

    always @(posedge clk) begin
        if (pre_we) ram1[pre_idx] <= pre_data;
        else if (bus1.mem_en && bus1.mem_we) ram1[bus1.mem_addr[11:3]] <= bus1.mem_wdata;
        if (bus1.mem_en) rd_pipe1 <= ram1[bus1.mem_addr[11:3]];
    end
    assign bus1.mem_rdata = rd_pipe1;

    always @(posedge clk) begin
        if (pre_we) ram0[pre_idx] <= pre_data;
        else if (bus0.mem_en && bus0.mem_we) ram0[bus0.mem_addr[11:3]] <= bus0.mem_wdata;
    end
    assign bus0.mem_rdata = ram0[bus0.mem_addr[11:3]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [8:0] idx, input logic [63:0] data);
        pre_idx = idx; pre_data = data; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Single data access; request dropped and inputs scrambled after the grant.
    task automatic data_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               output int lat, output int we_cycles);
        @(posedge clk); #1;
        bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
        lat = -1; we_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.mem_en && bus1.mem_we) we_cycles++;
            if (k == 1) begin
                bus1.d_req = 1'b0; bus1.d_we = ~we; bus1.d_addr = '0; bus1.d_wdata = '0;
            end
            if (bus1.d_ack) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, wec, nacks, first, acks;
        logic [9:0]  seq;
        logic [4:0]  en_v, ack_v, st_v;
        logic [31:0] acc_rd;

        rst_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;

        preload(9'd8,  64'h1111_2222_8B02_0020);
        preload(9'd9,  64'h5555_6666_D280_0541);
        preload(9'd32, 64'h0000_0000_0000_1234);

        // Reset state.
        @(negedge clk);
        check("rst_mem_en", {62'd0, bus1.mem_en, bus1.mem_we}, 64'd0);
        check("rst_acks",   {62'd0, bus1.if_ack, bus1.d_ack}, 64'd0);
        check("rst_stall",  {63'd0, bus1.stall}, 64'd0);
        check("rst_rdata",  bus1.d_rdata | {32'd0, bus1.if_rdata}, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);
        check("idle_stall", {63'd0, bus1.stall}, 64'd0);

        // Single fetch, one wait state.
        @(posedge clk); #1;
        bus1.if_req = 1'b1; bus1.if_addr = 64'h40;
        @(negedge clk);                                   // cycle N (IDLE)
        check("f_stall_req", {63'd0, bus1.stall}, 64'd1);
        check("f_en_N",      {63'd0, bus1.mem_en}, 64'd0);
        @(negedge clk);                                   // N+1 (ACCESS)
        bus1.if_req = 1'b0;
        check("f_en_N1",   {63'd0, bus1.mem_en}, 64'd1);
        check("f_addr_N1", bus1.mem_addr, 64'h40);
        @(negedge clk);                                   // N+2 (WAIT)
        check("f_wait", {61'd0, bus1.mem_en, bus1.if_ack, bus1.stall}, 64'b001);
        @(negedge clk);                                   // N+3 (RESP)
        check("f_ack_N3",  {62'd0, bus1.if_ack, bus1.stall}, 64'b10);
        check("f_rdata",   {32'd0, bus1.if_rdata}, 64'h8B02_0020);
        @(negedge clk);
        check("f_ack_pulse", {63'd0, bus1.if_ack}, 64'd0);

        // Fairness: both held, burst limit 4.
        idle(2);
        bus1.if_req = 1'b1; bus1.if_addr = 64'h40;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 64'h100;
        seq = '0; nacks = 0;
        for (int k = 0; k < 120 && nacks < 10; k++) begin
            @(negedge clk);
            if (bus1.d_ack || bus1.if_ack) begin
                seq = {seq[8:0], bus1.d_ack};
                nacks++;
            end
        end
        @(posedge clk); #1;
        bus1.if_req = 1'b0; bus1.d_req = 1'b0;
        check("fair_order", {54'd0, seq}, {54'd0, 10'b1111011110});
        check("fair_count", 64'(nacks), 64'd10);
        idle(8);

        // Load then store to 0x100.
        data_access(1'b0, 64'h100, 64'h0, lat, wec);
        check("ld_lat",   64'(lat), 64'd3);
        check("ld_we",    64'(wec), 64'd0);
        check("ld_rdata", bus1.d_rdata, 64'h1234);
        idle(3);
        data_access(1'b1, 64'h100, 64'hDEAD, lat, wec);
        check("st_lat",   64'(lat), 64'd3);
        check("st_we",    64'(wec), 64'd1);
        check("st_rdata", bus1.d_rdata, 64'h1234);
        check("st_ram",   ram1[32], 64'hDEAD);
        idle(3);

        // Masking: d_req held through its ack, fetch idle.
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 64'h100;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.d_ack) begin
                first = k;
                break;
            end
        end
        check("mask_first_lat", 64'(first), 64'd3);
        en_v = '0; ack_v = '0; st_v = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en_v  = {en_v[3:0], bus1.mem_en};
            ack_v = {ack_v[3:0], bus1.d_ack};
            st_v  = {st_v[3:0], bus1.stall};
        end
        bus1.d_req = 1'b0;
        check("mask_en_seq",    {59'd0, en_v},  {59'd0, 5'b00100});
        check("mask_ack_seq",   {59'd0, ack_v}, {59'd0, 5'b00001});
        check("mask_stall_seq", {59'd0, st_v},  {59'd0, 5'b01110});
        idle(4);

        // Reset asserted during WAIT aborts the fetch.
        bus1.if_req = 1'b1; bus1.if_addr = 64'h48;        // cycle N
        @(posedge clk); #1;                               // N+1 ACCESS
        @(posedge clk); #1;                               // N+2 WAIT
        check("mr_wait_stall", {63'd0, bus1.stall}, 64'd1);
        rst_n = 1'b0; #1;
        check("mr_outputs", {60'd0, bus1.mem_en, bus1.stall, bus1.if_ack, bus1.d_ack}, 64'd0);
        @(posedge clk); #1;
        bus1.if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus1.if_ack || bus1.d_ack || bus1.mem_en) acks++;
        end
        check("mr_no_ack",  64'(acks), 64'd0);
        check("mr_if_rdata", {32'd0, bus1.if_rdata}, 64'd0);

        // Zero-wait-state build.
        @(posedge clk); #1;
        bus0.if_req = 1'b1; bus0.if_addr = 64'h48;
        lat = -1; acc_rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus0.if_req = 1'b0;
                check("ws0_en", {63'd0, bus0.mem_en}, 64'd1);
                acc_rd = bus0.mem_rdata[31:0];
            end
            if (bus0.if_ack) begin
                lat = k;
                break;
            end
        end
        check("ws0_lat",    64'(lat), 64'd2);
        check("ws0_acc_rd", {32'd0, acc_rd}, 64'hD280_0541);
        check("ws0_rdata",  {32'd0, bus0.if_rdata}, 64'hD280_0541);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
